// File: rtl/xc_aessub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xc_aessub_pkg
// Description : FSM state encoding and byte-lane indices for the shared
//               multi-cycle AES SubBytes engine.
// Revision    : 1.0 - initial release
// ============================================================================
package xc_aessub_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_sub  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [1:0] c_lane_0 = 2'd0;
    localparam logic [1:0] c_lane_1 = 2'd1;
    localparam logic [1:0] c_lane_2 = 2'd2;
    localparam logic [1:0] c_lane_3 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/xc_aessub_sbox.sv
`default_nettype none
// ============================================================================
// Module      : xc_aessub_sbox
// Description : Combinational AES S-box, forward or inverse (inv=1).
// Revision    : 1.0 - initial release
// ============================================================================
module xc_aessub_sbox (
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic [7:0] w_pre;
    logic [7:0] w_inv;

    assign w_pre = inv ? (rotl(in, 1) ^ rotl(in, 3) ^ rotl(in, 6) ^ 8'h05) : in;
    assign w_inv = gf_inv(w_pre);
    assign out   = inv ? w_inv
                       : (w_inv ^ rotl(w_inv, 1) ^ rotl(w_inv, 2) ^ rotl(w_inv, 3)
                          ^ rotl(w_inv, 4) ^ 8'h63);

endmodule
`default_nettype wire

// File: rtl/xc_aessub_ctl.sv
`default_nettype none
// ============================================================================
// Module      : xc_aessub_ctl
// Description : Two-requester arbiter and sequencer driving one shared S-box
//               over four bytes, with a buffered tagged response port.
// Revision    : 1.0 - initial release
// ============================================================================
module xc_aessub_ctl
    import xc_aessub_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0,
    parameter bit RR_INIT    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_rs1,
    input  logic [63:0] req_rs2,
    input  logic [1:0]  req_enc,
    input  logic [1:0]  req_rot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [1:0]      r_cnt;
    logic [3:0][7:0] r_ops;
    logic [3:0][7:0] r_b;
    logic            r_enc;
    logic            r_rot;
    logic            r_id;
    logic            r_last_grant;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [31:0]     r_rsp_result;

    logic            w_grant;
    logic            w_accept;
    logic [31:0]     w_sel_rs1;
    logic [31:0]     w_sel_rs2;
    logic [7:0]      w_sbox_in;
    logic [7:0]      w_sbox_out;
    logic            w_unused;

    // Only the bytes feeding the four lanes are ever looked at.
    assign w_unused = ^{req_rs1[63:56], req_rs1[47:40], req_rs1[31:24], req_rs1[15:8],
                        req_rs2[55:48], req_rs2[39:32], req_rs2[23:16], req_rs2[7:0]};

    always_comb begin
        w_grant = req_valid[1];
        if (req_valid[0] && req_valid[1]) begin
            w_grant = PRIO_FIXED ? 1'b0 : ~r_last_grant;
        end
    end

    assign w_sel_rs1 = w_grant ? req_rs1[63:32] : req_rs1[31:0];
    assign w_sel_rs2 = w_grant ? req_rs2[63:32] : req_rs2[31:0];

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = 2'b00;
        case (r_state)
            c_st_idle: begin
                if (!flush && (|req_valid)) begin
                    w_accept    = 1'b1;
                    req_ready   = w_grant ? 2'b10 : 2'b01;
                    w_state_nxt = c_st_sub;
                end
            end
            c_st_sub: begin
                if (r_cnt == c_lane_3) w_state_nxt = c_st_resp;
            end
            c_st_resp: begin
                if (rsp_ready) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (flush) w_state_nxt = c_st_idle;
    end

    always_comb begin
        case (r_cnt)
            c_lane_0: w_sbox_in = r_ops[0];
            c_lane_1: w_sbox_in = r_ops[1];
            c_lane_2: w_sbox_in = r_ops[2];
            default:  w_sbox_in = r_ops[3];
        endcase
    end

    xc_aessub_sbox u_sbox (
        .in  (w_sbox_in),
        .inv (~r_enc),
        .out (w_sbox_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= c_lane_0;
            r_ops        <= '0;
            r_b          <= '0;
            r_enc        <= 1'b0;
            r_rot        <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= RR_INIT;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_cnt       <= c_lane_0;
                r_rsp_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_accept) begin
                            r_ops        <= {w_sel_rs2[31:24], w_sel_rs1[23:16],
                                             w_sel_rs2[15:8],  w_sel_rs1[7:0]};
                            r_enc        <= req_enc[w_grant];
                            r_rot        <= req_rot[w_grant];
                            r_id         <= w_grant;
                            r_last_grant <= w_grant;
                            r_cnt        <= c_lane_0;
                        end
                    end
                    c_st_sub: begin
                        r_b[r_cnt] <= w_sbox_out;
                        r_cnt      <= r_cnt + 2'd1;
                        // Last lane bypasses b[3] so the response is ready one cycle earlier.
                        if (r_cnt == c_lane_3) begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_id     <= r_id;
                            r_rsp_result <= r_rot ? {r_b[2], r_b[1], r_b[0], w_sbox_out}
                                                  : {w_sbox_out, r_b[2], r_b[1], r_b[0]};
                        end
                    end
                    c_st_resp: begin
                        if (rsp_ready) r_rsp_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;

endmodule
`default_nettype wire

// File: tb/tb_xc_aessub_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_xc_aessub_ctl
// Description : Directed self-checking bench for the shared SubBytes engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xc_aessub_ctl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  fx_req_valid = 2'b00;
    logic [63:0] req_rs1 = 64'h0;
    logic [63:0] req_rs2 = 64'h0;
    logic [1:0]  req_enc = 2'b00;
    logic [1:0]  req_rot = 2'b00;
    logic        rsp_ready = 1'b1;

    logic [1:0]  req_ready, fx_req_ready;
    logic        rsp_valid, fx_rsp_valid;
    logic        rsp_id, fx_rsp_id;
    logic [31:0] rsp_result, fx_rsp_result;

    int n_checks = 0;
    int n_errors = 0;
    int ng;
    logic [3:0] grants;
    int acc_cyc [4];

    always #5 clock = ~clock;

    xc_aessub_ctl #(.PRIO_FIXED(1'b0), .RR_INIT(1'b1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_enc(req_enc), .req_rot(req_rot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
    );

    xc_aessub_ctl #(.PRIO_FIXED(1'b1), .RR_INIT(1'b1)) dut_fx (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(fx_req_valid), .req_ready(fx_req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_enc(req_enc), .req_rot(req_rot),
        .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fx_rsp_id),
        .rsp_result(fx_rsp_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 2'b00;
        fx_req_valid = 2'b00;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_req(input logic id, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic enc, input logic rot);
        if (id) begin
            req_rs1[63:32] = rs1;
            req_rs2[63:32] = rs2;
        end else begin
            req_rs1[31:0] = rs1;
            req_rs2[31:0] = rs2;
        end
        req_enc[id] = enc;
        req_rot[id] = rot;
    endtask

    // Drive one request at a negedge and check it is accepted in that cycle (T).
    task automatic issue(input string tag, input logic id, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic enc, input logic rot);
        @(negedge clock);
        set_req(id, rs1, rs2, enc, rot);
        req_valid = id ? 2'b10 : 2'b01;
        #1 chk({tag, "_ready"}, 32'(req_ready), id ? 32'd2 : 32'd1);
    endtask

    // From T: response must be absent at T+4, present at T+5, consumed by T+6.
    task automatic finish_op(input string tag, input logic id, input logic [31:0] exp);
        @(negedge clock);
        req_valid = 2'b00;
        repeat (3) @(negedge clock);
        #1 chk({tag, "_early"}, 32'(rsp_valid), 32'd0);
        @(negedge clock);
        #1;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_result"}, rsp_result, exp);
        @(negedge clock);
        #1 chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_result", rsp_result, 32'h0);

        issue("r0_zero", 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        finish_op("r0_zero", 1'b0, 32'h6363_6363);

        issue("r1_fwd", 1'b1, 32'h00FF_0001, 32'h5300_0000, 1'b1, 1'b0);
        finish_op("r1_fwd", 1'b1, 32'hED16_637C);

        issue("r1_rot", 1'b1, 32'h00FF_0001, 32'h5300_0000, 1'b1, 1'b1);
        finish_op("r1_rot", 1'b1, 32'h1663_7CED);

        issue("r0_inv", 1'b0, 32'h0063_0063, 32'h6300_6300, 1'b0, 1'b0);
        finish_op("r0_inv", 1'b0, 32'h0000_0000);

        // Round-robin contention from a fresh reset.
        do_reset();
        set_req(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        set_req(1'b1, 32'h00FF_0001, 32'h5300_0000, 1'b1, 1'b0);
        ng = 0;
        @(negedge clock);
        req_valid = 2'b11;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready != 2'b00 && ng < 4) begin
                grants[ng]  = req_ready[1];
                acc_cyc[ng] = c;
                ng++;
            end
            @(negedge clock);
        end
        req_valid = 2'b00;
        chk("rr_count", 32'(ng), 32'd4);
        chk("rr_g0", 32'(grants[0]), 32'd0);
        chk("rr_g1", 32'(grants[1]), 32'd1);
        chk("rr_g2", 32'(grants[2]), 32'd0);
        chk("rr_g3", 32'(grants[3]), 32'd1);
        chk("rr_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);

        // Fixed priority contention.
        do_reset();
        ng = 0;
        @(negedge clock);
        fx_req_valid = 2'b11;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (fx_req_ready != 2'b00 && ng < 4) begin
                grants[ng] = fx_req_ready[1];
                ng++;
            end
            @(negedge clock);
        end
        fx_req_valid = 2'b00;
        chk("fx_count", 32'(ng), 32'd4);
        chk("fx_grants", 32'(grants), 32'd0);

        // Backpressure: response held for 10 cycles while req0 waits.
        do_reset();
        rsp_ready = 1'b0;
        issue("bp", 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clock);
        req_valid = 2'b00;
        repeat (3) @(negedge clock);
        set_req(1'b0, 32'h00FF_0001, 32'h5300_0000, 1'b1, 1'b0);
        req_valid = 2'b01;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            #1;
            chk("bp_hold_ctl", {29'd0, rsp_valid, rsp_id, 1'b0} | 32'(req_ready), 32'd6);
            chk("bp_hold_res", rsp_result, 32'h6363_6363);
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        #1;
        chk("bp_accept", 32'(req_ready), 32'd1);
        chk("bp_after_valid", 32'(rsp_valid), 32'd0);
        chk("bp_after_result", rsp_result, 32'h6363_6363);
        finish_op("bp_next", 1'b0, 32'hED16_637C);

        // Flush in the second SUB cycle, then a clean request.
        do_reset();
        issue("fl", 1'b0, 32'h00FF_0001, 32'h5300_0000, 1'b1, 1'b0);
        @(negedge clock);
        req_valid = 2'b00;
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        set_req(1'b0, 32'h00FF_0001, 32'h5300_0000, 1'b1, 1'b1);
        req_valid = 2'b01;
        #1;
        chk("fl_no_ready", 32'(req_ready), 32'd0);
        chk("fl_no_valid", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        flush = 1'b0;
        #1 chk("fl_idle_ready", 32'(req_ready), 32'd1);
        finish_op("fl_next", 1'b0, 32'h1663_7CED);

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        issue("rr", 1'b1, 32'h00FF_0001, 32'h5300_0000, 1'b1, 1'b0);
        @(negedge clock);
        req_valid = 2'b00;
        repeat (4) @(negedge clock);
        #1 chk("rr_pending", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("rr_valid", 32'(rsp_valid), 32'd0);
        chk("rr_id", 32'(rsp_id), 32'd0);
        chk("rr_result", rsp_result, 32'h0);
        chk("rr_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1 chk("rr_quiet", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
